seg_scan_capture: RTL and testbench
===================================

Name: seg_scan_capture

Overview:
Receive-side counterpart of the 6-digit display scan multiplexer. Samples the time-multiplexed segment bus (one-hot digit select plus 8-bit segment byte) and rebuilds the full 48-bit frame, with digit 0 in bits [7:0] and digit 5 in bits [47:40]. Checks scan order and reports errors. Sits on the board/monitor side of the display bus and is also used as a self-check monitor in the clock top level.

Parameters:
DIGITS, 6, number of scanned digits; width of seg_com; rotation length.
SEG_W, 8, width of one segment byte.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
sample_en  input  1  one-cycle strobe; seg_com/seg_data are sampled only when it is 1.
seg_com  input  DIGITS  one-hot digit select; bit i = digit i.
seg_data  input  SEG_W  segment byte for the selected digit.
frame_data  output  DIGITS*SEG_W  last complete frame; digit i occupies [i*SEG_W +: SEG_W].
frame_valid  output  1  one-cycle pulse when frame_data is updated.
locked  output  1  1 while in ASSEMBLE after at least one good frame since the last error or reset.
seq_err  output  1  one-cycle pulse on a scan-order or encoding error.
err_cnt  output  ERR_W  saturating count of seq_err events.

Behaviour:
- Reset (rst=0, asynchronous):
  - frame_data=0, frame_valid=0, locked=0, seq_err=0, err_cnt=0.
  - Shadow buffer=0, expected index=0, state=HUNT.
- Inputs are evaluated only on cycles with sample_en=1. With sample_en=0, all state holds, and frame_valid and seq_err return to 0.
- Sample classification:
  - Valid: seg_com is exactly one-hot. Its index k is derived from the one-hot position.
  - Invalid: seg_com is zero or has more than one bit set.
- State HUNT:
  - Valid k=0: write seg_data to shadow[0], set expected index=1, go to ASSEMBLE.
  - Any other sample: ignored. No error, stay in HUNT.
- State ASSEMBLE, expected index e:
  - Valid k==e, e<DIGITS-1: write shadow[e], e<=e+1.
  - Valid k==e, e==DIGITS-1:
    - frame_data <= shadow with digit DIGITS-1 merged from seg_data in the same cycle.
    - frame_valid=1 for one cycle; locked<=1; e<=0; stay in ASSEMBLE.
  - Invalid sample, or valid k!=e:
    - seq_err=1 for one cycle; err_cnt<=err_cnt+1, holding at all-ones (no wrap); locked<=0.
    - If the sample is valid with k==0: resync. Write shadow[0], set e=1, stay in ASSEMBLE.
    - Otherwise go to HUNT.
- Latency: a frame_valid pulse and the new frame_data appear on the clock edge that samples digit DIGITS-1. Both are registered outputs, visible the cycle after the sampling cycle.
- Retention:
  - frame_data changes only on frame completion.
  - An aborted partial frame never reaches frame_data.
  - The shadow buffer is not cleared on error, only overwritten.
- Wrap-around: after completing digit DIGITS-1, the next expected digit is 0. Back-to-back frames are captured with no gap cycles.
- Simultaneous error and saturation: seq_err still pulses; err_cnt stays at max.
- Reset mid-frame: the partial frame is discarded, outputs return to reset values, and capture restarts in HUNT.

Decomposition:
- Shared display package holds:
  - DIGITS and SEG_W constants (shared with the scan multiplexer).
  - The capture state enum {HUNT, ASSEMBLE}.
  - A one-hot-to-index function with a one-hot validity flag.
- One sub-module: onehot_decode (combinational, DIGITS-bit input → index plus valid). Everything else stays in seg_scan_capture.

Test Plan:
1. Reset, then six sample_en strobes with seg_com 000001..100000 and seg_data 11,22,33,44,55,66 (hex) → one frame_valid pulse; frame_data=0x665544332211; locked=1; err_cnt=0.
2. Start mid-rotation: strobes with com 000100, 001000, then a full 000001..100000 rotation → no seq_err during HUNT; exactly one frame_valid; frame_data holds only the last rotation's bytes.
3. Locked, then after digit 2 inject com 010000 → seq_err pulse, err_cnt=1, locked=0, HUNT; frame_data unchanged until the next complete frame.
4. Locked, then mid-frame com=000000 or 000011 → seq_err; err_cnt increments; next com 000001 restarts; subsequent complete frame sets locked=1.
5. Force 300 consecutive order errors (alternate com 000001, 000100) → err_cnt saturates at 0xFF and does not wrap; seq_err still pulses every error.
6. Continuous rotation with sample_en every cycle for 3 frames, then rst=0 asserted asynchronously mid-frame 4 → frame_valid on every 6th sample; on reset all outputs return to 0 immediately, independent of clk.

Source files
------------

// File: rtl/seg_scan_capture_pkg.sv
// Shared display-bus constants, capture state encoding and the one-hot
// digit-select decode used by the scan capture monitor.
package seg_scan_capture_pkg;
  localparam int DIGITS = 6;
  localparam int SEG_W  = 8;
  localparam int IDX_W  = $clog2(DIGITS);

  typedef enum logic {HUNT, ASSEMBLE} cap_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } onehot_res_t;

  // Exactly one bit set -> valid, idx is that bit's position.
  function automatic onehot_res_t onehot_idx(input logic [DIGITS-1:0] com);
    onehot_res_t r;
    int          n;
    r = '0;
    n = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (com[i]) begin
        n++;
        r.idx = IDX_W'(i);
      end
    end
    r.valid = (n == 1);
    return r;
  endfunction
endpackage

// File: rtl/seg_scan_capture_if.sv
// Segment bus plus reconstructed-frame status; master drives the bus,
// slave is the capture monitor.
interface seg_scan_capture_if
  import seg_scan_capture_pkg::*;
#(
    parameter int ERR_W = 8
);
    logic                      sample_en;
    logic [DIGITS-1:0]         seg_com;
    logic [SEG_W-1:0]          seg_data;
    logic [DIGITS*SEG_W-1:0]   frame_data;
    logic                      frame_valid;
    logic                      locked;
    logic                      seq_err;
    logic [ERR_W-1:0]          err_cnt;

    modport master (
        output sample_en, seg_com, seg_data,
        input  frame_data, frame_valid, locked, seq_err, err_cnt
    );

    modport slave (
        input  sample_en, seg_com, seg_data,
        output frame_data, frame_valid, locked, seq_err, err_cnt
    );
endinterface

// File: rtl/seg_scan_capture_onehot_decode.sv
// Combinational digit-select decode: one-hot position plus validity flag.
module onehot_decode
  import seg_scan_capture_pkg::*;
(
    input  logic [DIGITS-1:0] com_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              valid_o
);
    onehot_res_t res;

    assign res     = onehot_idx(com_i);
    assign idx_o   = res.idx;
    assign valid_o = res.valid;
endmodule

// File: rtl/seg_scan_capture.sv
// Rebuilds 48-bit display frames from the time-multiplexed segment bus,
// checking scan order and counting errors (saturating).
module seg_scan_capture
  import seg_scan_capture_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seg_scan_capture_if.slave    bus
);
    typedef logic [DIGITS-1:0][SEG_W-1:0] frame_t;

    cap_state_e       state_q, state_d;
    logic [IDX_W-1:0] exp_q, exp_d;
    frame_t           shadow_q, shadow_d;
    frame_t           frame_q, frame_d;
    logic             fv_q, fv_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] k;
    logic             k_vld;

    onehot_decode u_dec (
        .com_i   (bus.seg_com),
        .idx_o   (k),
        .valid_o (k_vld)
    );

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        fv_d     = 1'b0;
        locked_d = locked_q;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        if (bus.sample_en) begin
            unique case (state_q)
                HUNT: begin
                    // Out-of-order samples while hunting are silently dropped.
                    if (k_vld && k == '0) begin
                        shadow_d[0] = bus.seg_data;
                        exp_d       = IDX_W'(1);
                        state_d     = ASSEMBLE;
                    end
                end
                ASSEMBLE: begin
                    if (k_vld && k == exp_q) begin
                        shadow_d[exp_q] = bus.seg_data;
                        if (exp_q == IDX_W'(DIGITS-1)) begin
                            // Last digit bypasses the shadow so the frame lands this edge.
                            frame_d           = shadow_q;
                            frame_d[DIGITS-1] = bus.seg_data;
                            fv_d              = 1'b1;
                            locked_d          = 1'b1;
                            exp_d             = '0;
                        end else begin
                            exp_d = exp_q + 1'b1;
                        end
                    end else begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                        if (k_vld && k == '0) begin
                            shadow_d[0] = bus.seg_data;
                            exp_d       = IDX_W'(1);
                        end else begin
                            exp_d   = '0;
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= HUNT;
            exp_q    <= '0;
            shadow_q <= '0;
            frame_q  <= '0;
            fv_q     <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            fv_q     <= fv_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.frame_data  = frame_q;
    assign bus.frame_valid = fv_q;
    assign bus.locked      = locked_q;
    assign bus.seq_err     = err_q;
    assign bus.err_cnt     = cnt_q;
endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed plus randomized check of seg_scan_capture against a behavioural
// frame-assembly model.
module tb_seg_scan_capture;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   n_fv;
    int   n_err;

    seg_scan_capture_if #(.ERR_W(8)) bus ();

    seg_scan_capture #(.ERR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain ints/bytes, unbounded error tally.
    bit          m_hunt;
    int          m_e;
    logic [7:0]  m_sh [6];
    logic [47:0] m_frame;
    bit          m_fv;
    bit          m_lock;
    bit          m_err;
    int          m_errs;

    task automatic model_reset();
        m_hunt = 1; m_e = 0; m_frame = '0; m_fv = 0; m_lock = 0; m_err = 0; m_errs = 0;
        for (int i = 0; i < 6; i++) m_sh[i] = '0;
    endtask

    task automatic model_step(input bit en, input logic [5:0] com, input logic [7:0] data);
        bit good;
        int k;
        m_fv = 0; m_err = 0;
        if (!en) return;
        good = ($countones(com) == 1);
        k = -1;
        for (int i = 0; i < 6; i++) if (com[i]) k = i;
        if (m_hunt) begin
            if (good && k == 0) begin m_sh[0] = data; m_e = 1; m_hunt = 0; end
        end else if (good && k == m_e) begin
            m_sh[k] = data;
            if (k == 5) begin
                for (int i = 0; i < 6; i++) m_frame[i*8 +: 8] = m_sh[i];
                m_fv = 1; m_lock = 1; m_e = 0;
            end else m_e++;
        end else begin
            m_err = 1; m_errs++; m_lock = 0;
            if (good && k == 0) begin m_sh[0] = data; m_e = 1; end
            else begin m_hunt = 1; m_e = 0; end
        end
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".frame_data"},  bus.frame_data, m_frame);
        chk({ctx, ".frame_valid"}, 48'(bus.frame_valid), 48'(m_fv));
        chk({ctx, ".locked"},      48'(bus.locked), 48'(m_lock));
        chk({ctx, ".seq_err"},     48'(bus.seq_err), 48'(m_err));
        chk({ctx, ".err_cnt"},     48'(bus.err_cnt), 48'((m_errs > 255) ? 255 : m_errs));
    endtask

    task automatic step(input string ctx, input bit en, input logic [5:0] com, input logic [7:0] data);
        @(negedge clk);
        bus.sample_en = en; bus.seg_com = com; bus.seg_data = data;
        @(posedge clk);
        model_step(en, com, data);
        #1;
        if (bus.frame_valid) n_fv++;
        if (bus.seq_err) n_err++;
        check_all(ctx);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.sample_en = 1'b0; bus.seg_com = '0; bus.seg_data = '0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic rotation(input string ctx, input logic [7:0] base);
        for (int i = 0; i < 6; i++) step(ctx, 1'b1, 6'(1 << i), base + 8'(i));
    endtask

    initial begin
        logic [47:0] saved;
        logic [5:0]  com;
        int          pick;
        tests = 0; fails = 0; n_fv = 0; n_err = 0;
        rst = 1'b1;
        bus.sample_en = 1'b0; bus.seg_com = '0; bus.seg_data = '0;
        model_reset();
        #3;
        do_reset();

        // 1: clean frame
        n_fv = 0;
        for (int i = 0; i < 6; i++) step("t1", 1'b1, 6'(1 << i), 8'h11 * 8'(i + 1));
        chk("t1.frame_lit", bus.frame_data, 48'h665544332211);
        chk("t1.locked_lit", 48'(bus.locked), 48'd1);
        chk("t1.fv_count", 48'(n_fv), 48'd1);
        step("t1.idle", 1'b0, 6'b000001, 8'h00);

        // 2: start mid-rotation from reset
        do_reset();
        n_fv = 0; n_err = 0;
        step("t2", 1'b1, 6'b000100, 8'hAA);
        step("t2", 1'b1, 6'b001000, 8'hBB);
        rotation("t2", 8'hA0);
        chk("t2.frame_lit", bus.frame_data, 48'hA5A4A3A2A1A0);
        chk("t2.fv_count", 48'(n_fv), 48'd1);
        chk("t2.err_count", 48'(n_err), 48'd0);

        // 3: order error after digit 2 while locked
        saved = bus.frame_data;
        for (int i = 0; i < 3; i++) step("t3", 1'b1, 6'(1 << i), 8'hC0 + 8'(i));
        step("t3.bad", 1'b1, 6'b010000, 8'hCF);
        chk("t3.seq_err_lit", 48'(bus.seq_err), 48'd1);
        chk("t3.err_cnt_lit", 48'(bus.err_cnt), 48'd1);
        chk("t3.frame_kept", bus.frame_data, saved);
        step("t3.hunt", 1'b1, 6'b000010, 8'h77);
        rotation("t3", 8'hD0);
        chk("t3.frame_new", bus.frame_data, 48'hD5D4D3D2D1D0);

        // 4: encoding errors mid-frame
        step("t4", 1'b1, 6'b000001, 8'h01);
        step("t4", 1'b1, 6'b000010, 8'h02);
        step("t4.zero", 1'b1, 6'b000000, 8'h03);
        rotation("t4", 8'hE0);
        step("t4", 1'b1, 6'b000001, 8'h01);
        step("t4.multi", 1'b1, 6'b000011, 8'h02);
        rotation("t4", 8'hF0);
        chk("t4.locked_lit", 48'(bus.locked), 48'd1);

        // 5: saturation
        n_err = 0;
        for (int i = 0; i < 600; i++) step("t5", 1'b1, (i % 2 == 0) ? 6'b000001 : 6'b000100, 8'(i));
        chk("t5.err_pulses", 48'(n_err), 48'd300);
        chk("t5.err_cnt_sat", 48'(bus.err_cnt), 48'hFF);

        // random mix
        do_reset();
        for (int i = 0; i < 400; i++) begin
            pick = $urandom_range(0, 99);
            if (pick < 70)      com = m_hunt ? 6'b000001 : 6'(1 << m_e);
            else if (pick < 85) com = 6'(1 << $urandom_range(0, 5));
            else                com = 6'($urandom);
            step("rand", ($urandom_range(0, 3) != 0), com, 8'($urandom));
        end

        // 6: continuous rotation then async reset mid-frame
        do_reset();
        n_fv = 0;
        for (int f = 0; f < 3; f++) rotation("t6", 8'(16 * f));
        chk("t6.fv_count", 48'(n_fv), 48'd3);
        step("t6", 1'b1, 6'b000001, 8'h99);
        step("t6", 1'b1, 6'b000010, 8'h98);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("t6.async");
        @(negedge clk);
        rst = 1'b1;
        step("t6.after", 1'b1, 6'b000100, 8'h55);
        rotation("t6.after", 8'h30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
